// File: rtl/spin_playback_sequencer_pkg.sv
// Shared configuration for the Ising machine spin datapath: sample width,
// GPIO bus field positions and the playback sequencer state encoding.
package ising_config;

  localparam int num_bits = 8;

  localparam int gpio_addr_lsb   = 0;
  localparam int gpio_addr_w     = 16;
  localparam int gpio_data_lsb   = 16;
  localparam int gpio_data_w     = 8;
  localparam int gpio_strobe_bit = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/spin_playback_sequencer_ram.sv
// Simple dual-port spin buffer: one write port, one registered read port.
// Contents are never reset so loaded patterns survive a sequencer reset.
module spin_buffer_ram #(
  parameter int depth = 64,
  parameter int width = 8,
  localparam int aw = $clog2(depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  // Read-before-write: a same-cycle write and read of one entry returns old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/spin_playback_sequencer.sv
// Replays the first play_len buffered spin amplitudes for round_count rounds,
// with gap_cycles idle cycles between rounds; buffer is loaded over GPIO.
module spin_playback_sequencer
  import ising_config::*;
#(
  parameter int buf_base = 0,
  parameter int depth    = 64,
  localparam int aw = $clog2(depth)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         gpio_in,
  input  logic                start,
  input  logic                abort,
  input  logic [aw:0]         play_len,
  input  logic [15:0]         round_count,
  input  logic [15:0]         gap_cycles,
  output logic [num_bits-1:0] val_out,
  output logic                val_out_valid,
  output logic                busy,
  output logic                done,
  output logic [15:0]         round_idx,
  output seq_state_t          state_dbg
);

  logic [gpio_strobe_bit:0] gpio_q;
  logic                     stb_d;
  logic [16:0]              wr_off;
  logic                     wr_en;
  logic [aw-1:0]            wr_addr;
  logic [num_bits-1:0]      wr_data;
  logic                     unused_gpio;

  seq_state_t          state;
  logic [aw-1:0]       idx;
  logic [aw:0]         len;
  logic [15:0]         rounds;
  logic [15:0]         gap;
  logic [15:0]         rnd;
  logic [15:0]         gcnt;
  logic [num_bits-1:0] rd_data;
  logic                last_idx;
  logic                last_round;

  assign unused_gpio = ^gpio_in[31:gpio_strobe_bit+1];

  // Addresses below buf_base wrap to >= 2^16 in 17 bits, so one compare covers both ends.
  always_comb begin
    wr_off  = {1'b0, gpio_q[gpio_addr_lsb +: gpio_addr_w]} - 17'(buf_base);
    wr_en   = gpio_q[gpio_strobe_bit] & ~stb_d & (wr_off < 17'(depth));
    wr_addr = wr_off[aw-1:0];
    wr_data = gpio_q[gpio_data_lsb +: num_bits];
  end

  assign last_idx   = ({1'b0, idx} == (len - (aw+1)'(1)));
  assign last_round = (rnd == (rounds - 16'd1));

  spin_buffer_ram #(.depth(depth), .width(num_bits)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (idx),
    .rdata (rd_data)
  );

  // Stream handshake: val_out carries a sample exactly when val_out_valid is
  // high; there is no backpressure, the consumer takes every valid cycle.
  assign val_out   = val_out_valid ? rd_data : '0;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_q        <= '0;
      stb_d         <= 1'b0;
      state         <= IDLE;
      idx           <= '0;
      len           <= '0;
      rounds        <= '0;
      gap           <= '0;
      rnd           <= '0;
      gcnt          <= '0;
      val_out_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      round_idx     <= '0;
    end else begin
      gpio_q        <= gpio_in[gpio_strobe_bit:0];
      stb_d         <= gpio_q[gpio_strobe_bit];
      done          <= 1'b0;
      val_out_valid <= (state == PLAY);
      if (state == PLAY) round_idx <= rnd;

      if (abort) begin
        state         <= IDLE;
        busy          <= 1'b0;
        val_out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              len    <= play_len;
              rounds <= round_count;
              gap    <= gap_cycles;
              idx    <= '0;
              rnd    <= '0;
              busy   <= 1'b1;
              state  <= (play_len == '0 || round_count == '0) ? FINISH : PLAY;
            end
          end
          PLAY: begin
            if (last_idx) begin
              idx <= '0;
              if (last_round) begin
                state <= FINISH;
              end else if (gap == '0) begin
                rnd <= rnd + 16'd1;
              end else begin
                state <= GAP;
                gcnt  <= 16'd1;
              end
            end else begin
              idx <= idx + aw'(1);
            end
          end
          GAP: begin
            if (gcnt == gap) begin
              state <= PLAY;
              rnd   <= rnd + 16'd1;
            end else begin
              gcnt <= gcnt + 16'd1;
            end
          end
          FINISH: begin
            // The last read lands on the edge that entered FINISH.
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spin_playback_sequencer.sv
// Directed and randomized playback runs checked against a per-cycle timeline
// computed from round/gap arithmetic over a shadow copy of the buffer.
module tb_spin_playback_sequencer;
  import ising_config::*;

  localparam int depth = 64;
  localparam int aw    = $clog2(depth);
  localparam int W     = 27;  // {done, busy, valid, round[15:0], value[7:0]}

  logic                clk = 1'b0;
  logic                rst;
  logic [31:0]         gpio_in;
  logic                start;
  logic                abort;
  logic [aw:0]         play_len;
  logic [15:0]         round_count;
  logic [15:0]         gap_cycles;
  logic [num_bits-1:0] val_out;
  logic                val_out_valid;
  logic                busy;
  logic                done;
  logic [15:0]         round_idx;
  seq_state_t          state_dbg;

  logic [7:0]   mem_model [depth];
  logic [W-1:0] exp_q [$];
  int           tests = 0;
  int           fails = 0;

  spin_playback_sequencer #(.buf_base(0), .depth(depth)) dut (
    .clk           (clk),
    .rst           (rst),
    .gpio_in       (gpio_in),
    .start         (start),
    .abort         (abort),
    .play_len      (play_len),
    .round_count   (round_count),
    .gap_cycles    (gap_cycles),
    .val_out       (val_out),
    .val_out_valid (val_out_valid),
    .busy          (busy),
    .done          (done),
    .round_idx     (round_idx),
    .state_dbg     (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic gpio_write(input int addr, input logic [7:0] data);
    gpio_in = {7'd0, 1'b1, data, 16'(addr)};
    tick();
    gpio_in[24] = 1'b0;
    tick();
    tick();
    if (addr < depth) mem_model[addr] = data;
  endtask

  task automatic held_strobe_write(input int addr, input logic [7:0] d0, input logic [7:0] d1);
    gpio_in = {7'd0, 1'b1, d0, 16'(addr)};
    tick();
    tick();
    gpio_in = {7'd0, 1'b1, d1, 16'(addr + 1)};
    repeat (3) tick();
    gpio_in[24] = 1'b0;
    repeat (2) tick();
    mem_model[addr] = d0;
  endtask

  // Model: start accepted at edge T; sample k is taken just after edge T+k-1.
  function automatic logic [W-1:0] model_word(input int k, input int L, input int G, input int done_s);
    logic       v;
    logic [7:0] val;
    int         r;
    int         j;
    v = 1'b0; val = 8'h00; r = 0;
    if (k >= 2 && k < done_s) begin
      r = (k - 2) / (L + G);
      j = (k - 2) % (L + G);
      if (j < L) begin
        v   = 1'b1;
        val = mem_model[j];
      end
    end
    return {(k == done_s), (k < done_s), v, 16'(r), val};
  endfunction

  task automatic check_sample(input int s, input logic [W-1:0] e);
    check($sformatf("done@%0d", s), 32'(done), 32'(e[26]));
    check($sformatf("busy@%0d", s), 32'(busy), 32'(e[25]));
    check($sformatf("valid@%0d", s), 32'(val_out_valid), 32'(e[24]));
    check($sformatf("val_out@%0d", s), 32'(val_out), 32'(e[7:0]));
    if (e[24]) check($sformatf("round_idx@%0d", s), 32'(round_idx), 32'(e[23:8]));
  endtask

  task automatic check_quiet(input string tag, input bit after_rst);
    check({tag, "_valid"}, 32'(val_out_valid), 32'd0);
    check({tag, "_val_out"}, 32'(val_out), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    if (after_rst) check({tag, "_round_idx"}, 32'(round_idx), 32'd0);
  endtask

  // Scoreboard-driven playback run; abort_s/rst_s interrupt at that sample.
  task automatic play(input int L, input int R, input int G, input int abort_s, input int rst_s,
                      input bit poke_start);
    int done_s;
    int s;
    logic [W-1:0] e;
    done_s = (L == 0 || R == 0) ? 2 : 2 + (R - 1) * (L + G) + L;
    for (int k = 1; k <= done_s + 1; k++) exp_q.push_back(model_word(k, L, G, done_s));
    play_len    = (aw+1)'(L);
    round_count = 16'(R);
    gap_cycles  = 16'(G);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_sample(s, e);
      if (s == abort_s || s == rst_s) begin
        if (s == abort_s) abort = 1'b1;
        else rst = 1'b1;
        tick();
        abort = 1'b0;
        rst   = 1'b0;
        check_quiet($sformatf("interrupt@%0d", s + 1), s == rst_s);
        repeat (3) begin
          tick();
          check_quiet("after_interrupt", 1'b0);
        end
        exp_q.delete();
      end else begin
        start = poke_start && (s == 2);
        tick();
        start = 1'b0;
        s++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; gpio_in = '0; start = 1'b0; abort = 1'b0;
    play_len = '0; round_count = '0; gap_cycles = '0;
    repeat (3) tick();
    check_quiet("reset", 1'b1);
    check("reset_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) gpio_write(i, 8'($urandom_range(0, 255)));
    gpio_write(0, 8'h10); gpio_write(1, 8'h20); gpio_write(2, 8'h30); gpio_write(3, 8'h40);

    play(4, 1, 0, -1, -1, 1'b0);
    play(3, 2, 2, -1, -1, 1'b0);
    gpio_write(0, 8'($urandom_range(0, 255)));
    gpio_write(1, 8'($urandom_range(0, 255)));
    play(2, 3, 0, -1, -1, 1'b0);

    play(4, 1, 0, 3, -1, 1'b0);
    play(4, 1, 0, -1, -1, 1'b0);

    gpio_write(depth, 8'hEE);
    held_strobe_write(5, 8'hA5, 8'h5A);
    play(7, 1, 0, -1, -1, 1'b0);

    play(0, 1, 0, -1, -1, 1'b0);
    play(3, 0, 0, -1, -1, 1'b0);

    play(4, 2, 1, -1, 4, 1'b0);
    play(4, 2, 1, -1, -1, 1'b0);

    for (int n = 0; n < 8; n++) begin
      repeat (3) gpio_write($urandom_range(0, 15), 8'($urandom_range(0, 255)));
      play($urandom_range(1, 16), $urandom_range(1, 3), $urandom_range(0, 3), -1, -1,
           1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
